demux_1to4_stream: RTL and testbench

- Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the 4:1 bus mux.
- Routes each word accepted on a single valid/ready input to one of four output channels, chosen by sel.
- Each channel has its own 2-entry FIFO, so one stalled consumer never blocks traffic to the others.
- Sits between a shared producer (e.g. a decode/issue stage) and up to four independent consumers.

---
 rtl/demux_1to4_stream.sv | 96 +++++++++
 tb/tb_demux_1to4_stream.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: registered 1-to-4 stream demultiplexer.
// Each accepted input word is steered by sel into one of four 2-entry FIFOs.
// Every FIFO drains independently, so a stalled consumer only backs up its own
// channel. in_ready looks only at registered occupancy and sel, which means
// there is no combinational path from out_ready to in_ready.
module demux_1to4_stream #(
  parameter int BUS_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           sel,
  output logic [BUS_WIDTH-1:0] out_data_a,
  output logic [BUS_WIDTH-1:0] out_data_b,
  output logic [BUS_WIDTH-1:0] out_data_c,
  output logic [BUS_WIDTH-1:0] out_data_d,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready
);

  logic [BUS_WIDTH-1:0] mem_q [4][2];
  logic [BUS_WIDTH-1:0] mem_d [4][2];
  logic [3:0]           rd_ptr_q, rd_ptr_d;
  logic [3:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           occ_q [4];
  logic [1:0]           occ_d [4];

  logic [3:0]           push;
  logic [3:0]           pop;
  logic [BUS_WIDTH-1:0] head [4];

  // Input handshake: the selected channel accepts unless it is full.
  always_comb begin
    in_ready = (occ_q[sel] != 2'd2);
  end

  // Per-channel push/pop strobes and head-of-queue outputs.
  always_comb begin
    push      = '0;
    pop       = '0;
    out_valid = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      out_valid[i] = (occ_q[i] != 2'd0);
      push[i]      = in_valid && in_ready && (sel == i[1:0]);
      pop[i]       = out_valid[i] && out_ready[i];
      head[i]      = out_valid[i] ? mem_q[i][rd_ptr_q[i]] : '0;
    end
  end

  assign out_data_a = head[0];
  assign out_data_b = head[1];
  assign out_data_c = head[2];
  assign out_data_d = head[3];

  // Next-state for storage, pointers and occupancy of every channel.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    for (int unsigned i = 0; i < 4; i++) begin
      occ_d[i] = occ_q[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data;
      end
      if (push[i] && !pop[i]) begin
        occ_d[i] = occ_q[i] + 2'd1;
      end else if (pop[i] && !push[i]) begin
        occ_d[i] = occ_q[i] - 2'd1;
      end
    end
  end

  // State registers; asynchronous reset empties every channel at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        occ_q[i]    <= '0;
        mem_q[i][0] <= '0;
        mem_q[i][1] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      for (int unsigned i = 0; i < 4; i++) begin
        occ_q[i]    <= occ_d[i];
        mem_q[i][0] <= mem_d[i][0];
        mem_q[i][1] <= mem_d[i][1];
      end
    end
  end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench for demux_1to4_stream using per-channel queues as the
// reference: a channel accepts while its queue holds fewer than two words,
// pops remove the front, and the front word is what the channel presents.
module tb_demux_1to4_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [3:0] out_data_a, out_data_b, out_data_c, out_data_d;
  logic [3:0] out_valid;
  logic [3:0] out_ready;

  int checks   = 0;
  int failures = 0;

  logic [3:0] q [4][$];

  demux_1to4_stream #(.BUS_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .out_data_a (out_data_a),
    .out_data_b (out_data_b),
    .out_data_c (out_data_c),
    .out_data_d (out_data_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Packed view of every DUT output: {in_ready, out_valid, d, c, b, a}.
  function automatic logic [20:0] obs_outs();
    return {in_ready, out_valid, out_data_d, out_data_c, out_data_b, out_data_a};
  endfunction

  // Same view predicted from the reference queues.
  function automatic logic [20:0] exp_outs();
    logic [3:0] v;
    logic [3:0] d [4];
    for (int i = 0; i < 4; i++) begin
      v[i] = (q[i].size() != 0);
      d[i] = v[i] ? q[i][0] : 4'h0;
    end
    return {(q[sel].size() != 2), v, d[3], d[2], d[1], d[0]};
  endfunction

  // Advance one clock edge and apply the same edge to the reference queues.
  task automatic tick();
    logic       acc;
    logic [1:0] s;
    logic [3:0] d;
    logic [3:0] pops;
    acc = in_valid && (q[sel].size() < 2);
    s   = sel;
    d   = in_data;
    for (int i = 0; i < 4; i++) pops[i] = out_ready[i] && (q[i].size() != 0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (pops[i]) void'(q[i].pop_front());
    if (acc) q[s].push_back(d);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) q[i].delete();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 4'hF;
    repeat (3) tick();
    out_ready = 4'h0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; sel = 2'd0; out_ready = 4'h0;
    clear_model();
    #12;
    checks++;
    if (obs_outs() !== {1'b1, 4'b0000, 16'h0000}) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", obs_outs(), {1'b1, 4'b0000, 16'h0000});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; sel = 2'd0; in_data = 4'hA; tick();
    in_data = 4'hB; tick();
    in_valid = 1'b0; #1;
    checks++;
    if (obs_outs() !== exp_outs()) begin
      failures++;
      $display("FAIL reset_fill: got %h expected %h", obs_outs(), exp_outs());
    end
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    checks++;
    if (out_valid !== 4'b0000 || out_data_a !== 4'h0) begin
      failures++;
      $display("FAIL reset_async: got valid=%b a=%h expected valid=0000 a=0", out_valid, out_data_a);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0000", in_ready, out_valid);
    end
  endtask

  task automatic test_latency_order();
    out_ready = 4'h0; in_valid = 1'b1; sel = 2'd0; in_data = 4'h3;
    tick();
    checks++;
    if (out_valid[0] !== 1'b1 || out_data_a !== 4'h3) begin
      failures++;
      $display("FAIL latency_first: got valid0=%b a=%h expected valid0=1 a=3", out_valid[0], out_data_a);
    end
    in_data = 4'h5;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL latency_full: got in_ready=%b expected 0", in_ready);
    end
    out_ready = 4'b0001; #1;
    checks++;
    if (out_data_a !== 4'h3) begin
      failures++;
      $display("FAIL order_head0: got a=%h expected 3", out_data_a);
    end
    tick();
    checks++;
    if (out_data_a !== 4'h5 || out_valid[0] !== 1'b1) begin
      failures++;
      $display("FAIL order_head1: got a=%h valid0=%b expected a=5 valid0=1", out_data_a, out_valid[0]);
    end
    tick();
    checks++;
    if (out_valid[0] !== 1'b0 || obs_outs() !== exp_outs()) begin
      failures++;
      $display("FAIL order_empty: got %h expected %h", obs_outs(), exp_outs());
    end
    out_ready = 4'h0;
  endtask

  task automatic test_isolation();
    out_ready = 4'h0; in_valid = 1'b1; sel = 2'd1;
    in_data = 4'h1; tick();
    in_data = 4'h2; tick();
    in_data = 4'h9; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL iso_b_full: got in_ready=%b expected 0", in_ready);
    end
    tick();
    sel = 2'd2; in_data = 4'hC; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL iso_c_ready: got in_ready=%b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 4'b0110 || out_data_c !== 4'hC || out_data_b !== 4'h1 ||
        out_data_a !== 4'h0 || out_data_d !== 4'h0) begin
      failures++;
      $display("FAIL iso_landing: got valid=%b a=%h b=%h c=%h d=%h expected valid=0110 a=0 b=1 c=c d=0",
               out_valid, out_data_a, out_data_b, out_data_c, out_data_d);
    end
    drain();
  endtask

  task automatic test_full_pop();
    out_ready = 4'h0; in_valid = 1'b1; sel = 2'd3;
    in_data = 4'h6; tick();
    in_data = 4'h7; tick();
    in_data = 4'h8; out_ready = 4'b1000; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_ready: got in_ready=%b expected 0", in_ready);
    end
    tick();
    out_ready = 4'h0; #1;
    checks++;
    if (in_ready !== 1'b1 || out_data_d !== 4'h7 || out_valid[3] !== 1'b1) begin
      failures++;
      $display("FAIL fullpop_occ1: got ready=%b d=%h valid3=%b expected ready=1 d=7 valid3=1",
               in_ready, out_data_d, out_valid[3]);
    end
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b0 || obs_outs() !== exp_outs()) begin
      failures++;
      $display("FAIL fullpop_accept: got %h expected %h", obs_outs(), exp_outs());
    end
    out_ready = 4'b1000; tick();
    checks++;
    if (out_data_d !== 4'h8) begin
      failures++;
      $display("FAIL fullpop_order: got d=%h expected 8", out_data_d);
    end
    drain();
  endtask

  task automatic test_streaming();
    int bad_ready = 0;
    int bad_head  = 0;
    int bad_model = 0;
    logic [3:0] head;
    out_ready = 4'hF; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      sel = 2'($urandom_range(0, 3));
      in_data = 4'($urandom);
      #1;
      if (in_ready !== 1'b1) bad_ready++;
      tick();
      case (sel)
        2'd0: head = out_data_a;
        2'd1: head = out_data_b;
        2'd2: head = out_data_c;
        default: head = out_data_d;
      endcase
      if (head !== in_data || out_valid[sel] !== 1'b1) bad_head++;
      if (obs_outs() !== exp_outs()) bad_model++;
    end
    checks++;
    if (bad_ready != 0) begin
      failures++;
      $display("FAIL stream_ready: got %0d cycles with in_ready low, expected 0", bad_ready);
    end
    checks++;
    if (bad_head != 0) begin
      failures++;
      $display("FAIL stream_latency: got %0d late/wrong words, expected 0", bad_head);
    end
    checks++;
    if (bad_model != 0) begin
      failures++;
      $display("FAIL stream_model: got %0d output mismatches, expected 0", bad_model);
    end
    drain();
  endtask

  task automatic test_spurious_ready();
    int bad = 0;
    in_valid = 1'b0; out_ready = 4'hF;
    for (int n = 0; n < 10; n++) begin
      sel = 2'(n);
      in_data = 4'($urandom);
      tick();
      if (out_valid !== 4'b0000 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL spurious_ready: got %0d cycles with valid!=0000 or ready low, expected 0", bad);
    end
    in_valid = 1'b1; sel = 2'd2; in_data = 4'hE; out_ready = 4'h0;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 4'b0100 || out_data_c !== 4'hE) begin
      failures++;
      $display("FAIL spurious_no_underflow: got valid=%b c=%h expected valid=0100 c=e", out_valid, out_data_c);
    end
    drain();
  endtask

  task automatic test_random_traffic();
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom);
      sel       = 2'($urandom);
      in_data   = 4'($urandom);
      out_ready = 4'($urandom);
      #1;
      if (obs_outs() !== exp_outs()) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle%0d: got %h expected %h", n, obs_outs(), exp_outs());
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL random_traffic: got %0d mismatching cycles, expected 0", bad);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency_order();
    test_isolation();
    test_full_pop();
    test_streaming();
    test_spurious_ready();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
